uart_rx: RTL and testbench

UART receive stage that directly consumes the oversampling tick from the baud-rate generator. It recovers 8N1 frames from the serial line and presents each received byte with a one-clock done strobe. Frames that fail the stop-bit check are flagged. The block sits between the board RX pin and the MIPS debug/loader interface.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/oversampling
// parameters. The baud-rate generator and uart_tx take NUM_TICKS from here.
// Optional build macro: UART_RX_PARITY_EN (adds the PARITY receive state).
package uart_pkg;

  localparam int NB_DATA   = 8;   // data bits per frame, LSB first
  localparam int NUM_TICKS = 16;  // oversampling ticks per bit period
  localparam int SB_TICK   = 16;  // ticks spent sampling the stop bit

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  // Larger of two integers, used to size the shared tick counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs. The reset value is a
// parameter so an idle-high line (such as a UART RX pin) reads idle in reset.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by the baud generator's oversampling tick. Recovers
// 8N1 frames from a synchronized RX line, sampling each bit at its midpoint,
// and presents each byte with a one-cycle done strobe plus a stop-bit error
// flag. Optional build macro: UART_RX_PARITY_EN adds a parity bit between
// data and stop, parameter PARITY_ODD and output o_parity_err.
// o_dbg_state exposes the FSM state for observation.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA   = uart_pkg::NB_DATA,
  parameter int NUM_TICKS = uart_pkg::NUM_TICKS,
  parameter int SB_TICK   = uart_pkg::SB_TICK
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic               o_busy,
`ifdef UART_RX_PARITY_EN
  output logic               o_parity_err,
`endif
  output state_t             o_dbg_state
);

  localparam int TW = $clog2(max_int(NUM_TICKS, SB_TICK));
  localparam int BW = $clog2(NB_DATA);

  localparam logic [TW-1:0] MID_TICK  = TW'(NUM_TICKS / 2 - 1);
  localparam logic [TW-1:0] BIT_TICK  = TW'(NUM_TICKS - 1);
  localparam logic [TW-1:0] STOP_TICK = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NB_DATA - 1);

  // Handshake: o_rx_done is a single-cycle valid with no ready; o_data and
  // o_frame_err (and o_parity_err) are qualified by it in the same cycle,
  // and o_data holds until the next strobe.

  logic rx_s;

  state_t             state_q, state_d;
  logic [TW-1:0]      tick_q,  tick_d;
  logic [BW-1:0]      bit_q,   bit_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic [NB_DATA-1:0] data_q,  data_d;
  logic               done_q,  done_d;
  logic               ferr_q,  ferr_d;
`ifdef UART_RX_PARITY_EN
  logic               par_q,   par_d;
  logic               perr_q,  perr_d;
`endif

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .clk_i  (i_clk),
    .rst_ni (i_rst),
    .d_i    (i_rx),
    .q_o    (rx_s)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic: counters only move on ticks; the start edge does not wait for one.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (tick_q == MID_TICK) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              // Line went back high before mid-bit: treat as noise.
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (tick_q == BIT_TICK) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[NB_DATA-1:1]};
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (i_tick) begin
          if (tick_q == BIT_TICK) begin
            tick_d  = '0;
            par_d   = rx_s;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (i_tick) begin
          if (tick_q == STOP_TICK) begin
            state_d = ST_IDLE;
            data_d  = shreg_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shreg_q) ^ par_q ^ PARITY_ODD;
`endif
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit, the
// expected byte/flags are queued when a frame is driven and compared when the
// done strobe appears. Also covers reset, glitch rejection, sparse ticks,
// line break and reset in the middle of a frame.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int NBD = uart_pkg::NB_DATA;
  localparam int NT  = uart_pkg::NUM_TICKS;
  localparam int SBT = uart_pkg::SB_TICK;
  localparam bit PARITY_ODD_TB = 1'b0;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_tick;
  logic           i_rx;
  logic [NBD-1:0] o_data;
  logic           o_rx_done;
  logic           o_frame_err;
  logic           o_busy;
`ifdef UART_RX_PARITY_EN
  logic           o_parity_err;
`endif
  state_t         dbg_state;

  // Clock and reset: 10-unit clock; reset is driven by the stimulus process.
  always #5 i_clk = ~i_clk;

  uart_rx dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_rx_done    (o_rx_done),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy),
`ifdef UART_RX_PARITY_EN
    .o_parity_err (o_parity_err),
`endif
    .o_dbg_state  (dbg_state)
  );

  int checks        = 0;
  int errors        = 0;
  int cyc           = 0;
  int tick_div      = 1;
  int tdiv_cnt      = 0;
  int done_cnt      = 0;
  int last_done_cyc = 0;
  bit break_mode    = 1'b0;

  // Scoreboard entries: {parity_err, frame_err, data}.
  logic [NBD+1:0] exp_q[$];

  typedef struct {
    logic [NBD-1:0] data;
    logic           stop_bit;
    logic           par_flip;
    int             idle_bits;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor, called once per clock after the edge.
  task automatic monitor();
    logic [NBD+1:0] e;
    logic           perr_act;
`ifdef UART_RX_PARITY_EN
    perr_act = o_parity_err;
`else
    perr_act = 1'b0;
`endif
    if (o_rx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (break_mode) begin
        chk("break_frame_err", 32'(o_frame_err), 32'd1);
        chk("break_data", 32'(o_data), 32'd0);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with data 0x%0h, want no strobe (cycle %0d)", o_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("data", 32'(o_data), 32'(e[NBD-1:0]));
        chk("frame_err", 32'(o_frame_err), 32'(e[NBD]));
        chk("parity_err", 32'(perr_act), 32'(e[NBD+1]));
      end
    end else if (o_frame_err || perr_act) begin
      checks++;
      errors++;
      $display("FAIL flag_without_done: got ferr=%0b perr=%0b, want 0 (cycle %0d)", o_frame_err, perr_act, cyc);
    end
  endtask

  // Driver: one clock of line level, tick generated from the divider.
  task automatic step(input logic rx);
    i_rx = rx;
    if (tick_div <= 1) begin
      i_tick = 1'b1;
    end else begin
      i_tick   = (tdiv_cnt == 0);
      tdiv_cnt = (tdiv_cnt + 1) % tick_div;
    end
    @(posedge i_clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic send_level(input logic v, input int ticks);
    repeat (ticks * tick_div) step(v);
  endtask

  task automatic send_frame(input logic [NBD-1:0] d, input logic stop_bit,
                            input logic par_flip, input int idle_bits);
    logic pbit;
    logic exp_perr;
    pbit = (^d) ^ PARITY_ODD_TB ^ par_flip;
`ifdef UART_RX_PARITY_EN
    exp_perr = (^d) ^ pbit ^ PARITY_ODD_TB;
`else
    exp_perr = 1'b0;
`endif
    exp_q.push_back({exp_perr, ~stop_bit, d});
    send_level(1'b0, NT);
    for (int i = 0; i < NBD; i++) send_level(d[i], NT);
`ifdef UART_RX_PARITY_EN
    send_level(pbit, NT);
`endif
    send_level(stop_bit, SBT);
    repeat (idle_bits) send_level(1'b1, NT);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      step(1'b1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d frames undelivered, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int start_cyc;
    int lat;
    int n;
    int done0;

    vecs[0] = '{8'hA3, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h0F, 1'b1, 1'b0, 2};
    vecs[2] = '{8'hC4, 1'b0, 1'b0, 2};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 2};
    vecs[6] = '{8'h5A, 1'b1, 1'b0, 0};
    vecs[7] = '{8'h96, 1'b1, 1'b1, 2};

    // Reset with ticks running: nothing may move.
    i_rst  = 1'b0;
    i_rx   = 1'b1;
    i_tick = 1'b1;
    repeat (3) step(1'b1);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_done", 32'(o_rx_done), 32'd0);
    chk("rst_ferr", 32'(o_frame_err), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    i_rst = 1'b1;
    repeat (4) step(1'b1);
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Single 0x55 frame and start-edge to done latency.
    start_cyc = cyc;
    send_frame(8'h55, 1'b1, 1'b0, 2);
    drain("single_frame");
    lat = last_done_cyc - start_cyc;
    checks++;
    if (lat < 150 || lat > 164) begin
      errors++;
      $display("FAIL latency: got %0d clocks, want 150..164", lat);
    end

    // Table: back-to-back frames, framing errors, parity flips.
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_flip, vecs[i].idle_bits);
    end
    drain("table");

    // Short low glitch on an idle line.
    done0 = done_cnt;
    repeat (5) step(1'b0);
    chk("glitch_busy_rise", 32'(o_busy), 32'd1);
    repeat (20) step(1'b1);
    chk("glitch_busy_fall", 32'(o_busy), 32'd0);
    chk("glitch_no_done", 32'(done_cnt), 32'(done0));

    // Sparse ticks from a divider instead of every clock.
    tick_div = 13;
    tdiv_cnt = 0;
    send_frame(8'h3C, 1'b1, 1'b0, 1);
    drain("sparse_tick");
    tick_div = 1;

    // Asynchronous reset during data bit 4 of a frame, then a clean frame.
    send_level(1'b0, NT);
    for (int i = 0; i < 4; i++) send_level(1'(8'h11 >> i), NT);
    repeat (8) step(1'b0);
    #2 i_rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_rx_done), 32'd0);
    chk("midrst_data", 32'(o_data), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) step(1'b1);
    i_rst = 1'b1;
    repeat (4) step(1'b1);
    send_frame(8'h7E, 1'b1, 1'b0, 2);
    drain("after_reset");

    // Line held low: repeated frames with framing error, then recovery.
    break_mode = 1'b1;
    done0 = done_cnt;
    n = 0;
    while ((done_cnt - done0) < 3 && n < 2000) begin
      step(1'b0);
      n++;
    end
    break_mode = 1'b0;
    repeat (40) step(1'b1);
    chk("break_frames", 32'(done_cnt - done0), 32'd3);
    chk("break_recover_busy", 32'(o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
